// File: rtl/spi_ctrl_pkg.sv
// Shared types and helpers for the SPI transfer controller: FSM state encoding,
// SPI mode constants and a constant-foldable clog2.
package spi_ctrl_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StLoad  = 3'd1,
        StSetup = 3'd2,
        StShift = 3'd3,
        StStore = 3'd4,
        StGap   = 3'd5
    } spi_state_e;

    // SPI mode 0: SCLK idles low, MISO sampled while SCLK is high, MOSI changes on the fall.
    localparam logic SpiCpol = 1'b0;
    localparam logic SpiCpha = 1'b0;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        int unsigned v;
        res = 0;
        v   = (value > 0) ? value - 1 : 0;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/spi_xfer_ctrl_if.sv
// Bus bundle between the SPI transfer controller, its TX/RX word FIFOs and the SPI pins.
// The master modport is the controller's view; slave is the FIFO/pin side.
interface spi_xfer_ctrl_if #(
    parameter int unsigned g_width = 32
);
    logic               enable_i;
    logic [g_width-1:0] tx_data_i;
    logic               tx_empty_i;
    logic               tx_pull_o;
    logic [g_width-1:0] rx_data_o;
    logic               rx_full_i;
    logic               rx_push_o;
    logic               sclk_o;
    logic               mosi_o;
    logic               miso_i;
    logic               cs_n_o;
    logic               busy_o;

    modport master (
        input  enable_i, tx_data_i, tx_empty_i, rx_full_i, miso_i,
        output tx_pull_o, rx_data_o, rx_push_o, sclk_o, mosi_o, cs_n_o, busy_o
    );

    modport slave (
        output enable_i, tx_data_i, tx_empty_i, rx_full_i, miso_i,
        input  tx_pull_o, rx_data_o, rx_push_o, sclk_o, mosi_o, cs_n_o, busy_o
    );

endinterface

// File: rtl/spi_clk_div.sv
// SCLK half-period timer: counts g_div cycles and flags the last one with tick_o.
// clr_i restarts the period so every FSM state entry begins on a fresh count.
module spi_clk_div
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned g_div = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic tick_o
);

    localparam int unsigned CntW = clog2(g_div) + 1;
    localparam logic [CntW-1:0] CntLast = CntW'(g_div - 1);

    logic [CntW-1:0] div_cnt_q, div_cnt_d;

    always_comb begin
        tick_o    = (div_cnt_q == CntLast);
        div_cnt_d = (clr_i || tick_o) ? '0 : div_cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/spi_xfer_ctrl.sv
// SPI mode-0 master word sequencer between a FWFT TX FIFO, an RX FIFO and the SPI pins.
// Optional `SPI_XFER_CTRL_LOOPBACK_EN adds loopback_i, feeding MOSI back as MISO.
module spi_xfer_ctrl
    import spi_ctrl_pkg::*;
#(
    parameter int unsigned g_width = 32,
    parameter int unsigned g_div   = 4,
    parameter int unsigned g_gap   = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
    input  logic            loopback_i,
`endif
    spi_xfer_ctrl_if.master ctrl_if
);

    localparam int unsigned HalfW = clog2(2 * g_width) + 1;
    localparam int unsigned GapW  = clog2(g_gap + 1) + 1;
    localparam logic [HalfW-1:0] HalfLast     = HalfW'(2 * g_width - 1);
    localparam logic [HalfW-1:0] HalfLastHigh = HalfW'(2 * g_width - 2);
    localparam logic [GapW-1:0]  GapLast      = GapW'((g_gap > 0) ? g_gap - 1 : 0);

    spi_state_e state_q, state_d;

    logic               tick;
    logic               div_clr;
    logic               miso_src;
    logic [HalfW-1:0]   half_cnt_q, half_cnt_d;
    logic [GapW-1:0]    gap_cnt_q, gap_cnt_d;
    logic [g_width-2:0] tx_shift_q, tx_shift_d;
    logic [g_width-1:0] rx_shift_q, rx_shift_d;
    logic [g_width-1:0] rx_data_q, rx_data_d;
    logic               mosi_q, mosi_d;
    logic               sclk_q, sclk_d;
    logic               cs_n_q, cs_n_d;
    logic               tx_pull_q, tx_pull_d;
    logic               rx_push_q, rx_push_d;
    logic               busy_q, busy_d;

`ifdef SPI_XFER_CTRL_LOOPBACK_EN
    assign miso_src = loopback_i ? mosi_q : ctrl_if.miso_i;
`else
    assign miso_src = ctrl_if.miso_i;
`endif

    // Restart the half-period count on every state entry and whenever it is not timing.
    assign div_clr = (state_d != state_q) || !(state_q inside {StSetup, StShift});

    spi_clk_div #(
        .g_div (g_div)
    ) u_clk_div (
        .clk_i  (clk_i),
        .rst_ni (rst_i),
        .clr_i  (div_clr),
        .tick_o (tick)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ctrl_if.enable_i && !ctrl_if.tx_empty_i && !ctrl_if.rx_full_i) begin
                    state_d = StLoad;
                end
            end
            StLoad:  state_d = StSetup;
            StSetup: if (tick) state_d = StShift;
            StShift: if (tick && half_cnt_q == HalfLast) state_d = StStore;
            StStore: state_d = (g_gap > 0) ? StGap : StIdle;
            StGap:   if (gap_cnt_q == GapLast) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs are computed from the next state so each registered output lines up with
    // the state it belongs to.
    always_comb begin
        half_cnt_d = half_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_shift_d = tx_shift_q;
        rx_shift_d = rx_shift_q;
        mosi_d     = mosi_q;

        if (state_d != state_q) begin
            half_cnt_d = '0;
            gap_cnt_d  = '0;
        end else if (state_q == StShift && tick) begin
            half_cnt_d = half_cnt_q + HalfW'(1);
        end else if (state_q == StGap) begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
        end

        if (state_q == StLoad) begin
            tx_shift_d = ctrl_if.tx_data_i[g_width-2:0];
            rx_shift_d = '0;
            mosi_d     = ctrl_if.tx_data_i[g_width-1];
        end else if (state_q == StShift && tick && !half_cnt_q[0]) begin
            rx_shift_d = {rx_shift_q[g_width-2:0], miso_src};
            if (half_cnt_q != HalfLastHigh) begin
                mosi_d     = tx_shift_q[g_width-2];
                tx_shift_d = tx_shift_q << 1;
            end
        end

        sclk_d    = (state_d == StShift) ? (~half_cnt_d[0] ^ SpiCpol) : SpiCpol;
        cs_n_d    = !(state_d inside {StSetup, StShift});
        tx_pull_d = (state_d == StLoad);
        rx_push_d = (state_d == StStore);
        rx_data_d = (state_d == StStore) ? rx_shift_d : rx_data_q;
        busy_d    = (state_d != StIdle);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            half_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_shift_q <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= SpiCpol;
            cs_n_q     <= 1'b1;
            tx_pull_q  <= 1'b0;
            rx_push_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            half_cnt_q <= half_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_shift_q <= tx_shift_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            cs_n_q     <= cs_n_d;
            tx_pull_q  <= tx_pull_d;
            rx_push_q  <= rx_push_d;
            busy_q     <= busy_d;
        end
    end

    assign ctrl_if.tx_pull_o = tx_pull_q;
    assign ctrl_if.rx_data_o = rx_data_q;
    assign ctrl_if.rx_push_o = rx_push_q;
    assign ctrl_if.sclk_o    = sclk_q;
    assign ctrl_if.mosi_o    = mosi_q;
    assign ctrl_if.cs_n_o    = cs_n_q;
    assign ctrl_if.busy_o    = busy_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Directed bench for spi_xfer_ctrl (g_width=8, g_div=2, g_gap=1) with a TX FIFO model,
// a mode-0 SPI slave model and an RX capture queue.
module tb_spi_xfer_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic loopback = 1'b0;
    always #5 clk = ~clk;

    spi_xfer_ctrl_if #(.g_width(8)) bus_if ();

    spi_xfer_ctrl #(
        .g_width (8),
        .g_div   (2),
        .g_gap   (1)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_n),
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
        .loopback_i (loopback),
`endif
        .ctrl_if    (bus_if)
    );

    int total = 0;
    int bad = 0;
    int unsigned cyc = 0;

    logic [7:0] tx_q[$];
    logic [7:0] slave_q[$];
    logic [7:0] rx_got[$];
    int         pull_cyc[$];
    int pulls = 0, pushes = 0, both = 0, rises = 0, cs_high = 0, cs_min = 1000, bit_idx = 0;
    int push_cyc = 0;
    logic [7:0] mosi_bits = 8'h00;
    logic [7:0] slave_cur = 8'h00;
    logic sclk_prev = 1'b0, cs_prev = 1'b1, pop_pend = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // FIFO/slave model and bus monitor, all evaluated away from the active edge.
    always @(negedge clk) begin
        if (pop_pend && tx_q.size() > 0) tx_q.delete(0);
        pop_pend = bus_if.tx_pull_o;
        if (bus_if.tx_pull_o) begin
            pulls++;
            pull_cyc.push_back(cyc);
            slave_cur = (slave_q.size() > 0) ? slave_q.pop_front() : 8'h00;
        end
        if (bus_if.rx_push_o) begin
            pushes++;
            push_cyc = cyc;
            rx_got.push_back(bus_if.rx_data_o);
        end
        if (bus_if.tx_pull_o && bus_if.rx_push_o) both++;
        if (bus_if.sclk_o && !sclk_prev) begin
            rises++;
            mosi_bits = {mosi_bits[6:0], bus_if.mosi_o};
        end
        if (bus_if.cs_n_o) begin
            bit_idx = 0;
            cs_high++;
        end else begin
            if (cs_prev && cs_high < cs_min) cs_min = cs_high;
            cs_high = 0;
            if (!bus_if.sclk_o && sclk_prev) bit_idx++;
        end
        sclk_prev = bus_if.sclk_o;
        cs_prev   = bus_if.cs_n_o;
        bus_if.tx_empty_i = (tx_q.size() == 0);
        bus_if.tx_data_i  = (tx_q.size() > 0) ? tx_q[0] : 8'h00;
        bus_if.miso_i     = (bit_idx < 8) ? slave_cur[3'(7 - bit_idx)] : 1'b0;
    end

    task automatic clear_mon();
        pulls = 0; pushes = 0; both = 0; rises = 0; cs_min = 1000;
        rx_got.delete();
        pull_cyc.delete();
    endtask

    task automatic queue_word(input logic [7:0] tx, input logic [7:0] rsp);
        tx_q.push_back(tx);
        slave_q.push_back(rsp);
    endtask

    task automatic wait_rx(input int n, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (rx_got.size() >= n) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus_if.enable_i  = 1'b1;
        bus_if.rx_full_i = 1'b0;
        clear_mon();
        queue_word(8'hA5, 8'h3C);
        repeat (3) begin
            @(posedge clk); #1;
            total++; if (bus_if.cs_n_o !== 1'b1) begin bad++; $display("FAIL rst_cs_n: got %b want 1", bus_if.cs_n_o); end
            total++; if (bus_if.sclk_o !== 1'b0) begin bad++; $display("FAIL rst_sclk: got %b want 0", bus_if.sclk_o); end
            total++; if (bus_if.tx_pull_o !== 1'b0) begin bad++; $display("FAIL rst_pull: got %b want 0", bus_if.tx_pull_o); end
            total++; if (bus_if.busy_o !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", bus_if.busy_o); end
        end
        total++; if (bus_if.rx_data_o !== 8'h00) begin bad++; $display("FAIL rst_rx_data: got %h want 00", bus_if.rx_data_o); end
        total++; if (bus_if.mosi_o !== 1'b0) begin bad++; $display("FAIL rst_mosi: got %b want 0", bus_if.mosi_o); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (bus_if.tx_pull_o !== 1'b1) begin bad++; $display("FAIL first_load: got %b want 1", bus_if.tx_pull_o); end
        total++; if (bus_if.busy_o !== 1'b1) begin bad++; $display("FAIL first_busy: got %b want 1", bus_if.busy_o); end
    endtask

    task automatic test_single_word();
        bit ok;
        wait_rx(1, 100, ok);
        total++; if (!ok) begin bad++; $display("FAIL single_timeout: got %0d words want 1", rx_got.size()); end
        total++; if (rx_got[0] !== 8'h3C) begin bad++; $display("FAIL single_rx: got %h want 3c", rx_got[0]); end
        total++; if (mosi_bits !== 8'hA5) begin bad++; $display("FAIL single_mosi: got %h want a5", mosi_bits); end
        total++; if (rises !== 8) begin bad++; $display("FAIL single_rises: got %0d want 8", rises); end
        total++; if (pushes !== 1) begin bad++; $display("FAIL single_pushes: got %0d want 1", pushes); end
        total++; if (pulls !== 1) begin bad++; $display("FAIL single_pulls: got %0d want 1", pulls); end
        total++; if (push_cyc - pull_cyc[0] !== 35) begin bad++; $display("FAIL single_latency: got %0d want 35", push_cyc - pull_cyc[0]); end
        total++; if (bus_if.busy_o !== 1'b0) begin bad++; $display("FAIL single_idle: got %b want 0", bus_if.busy_o); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        clear_mon();
        queue_word(8'h12, 8'h81);
        queue_word(8'h34, 8'h42);
        queue_word(8'hC7, 8'h99);
        wait_rx(3, 300, ok);
        total++; if (!ok) begin bad++; $display("FAIL b2b_timeout: got %0d words want 3", rx_got.size()); end
        total++; if (pull_cyc[1] - pull_cyc[0] !== 38) begin bad++; $display("FAIL b2b_period0: got %0d want 38", pull_cyc[1] - pull_cyc[0]); end
        total++; if (pull_cyc[2] - pull_cyc[1] !== 38) begin bad++; $display("FAIL b2b_period1: got %0d want 38", pull_cyc[2] - pull_cyc[1]); end
        total++; if (rx_got[0] !== 8'h81) begin bad++; $display("FAIL b2b_rx0: got %h want 81", rx_got[0]); end
        total++; if (rx_got[1] !== 8'h42) begin bad++; $display("FAIL b2b_rx1: got %h want 42", rx_got[1]); end
        total++; if (rx_got[2] !== 8'h99) begin bad++; $display("FAIL b2b_rx2: got %h want 99", rx_got[2]); end
        total++; if (cs_min !== 4) begin bad++; $display("FAIL b2b_cs_high: got %0d want 4", cs_min); end
        total++; if (mosi_bits !== 8'hC7) begin bad++; $display("FAIL b2b_mosi: got %h want c7", mosi_bits); end
        total++; if (both !== 0) begin bad++; $display("FAIL b2b_pull_push_overlap: got %0d want 0", both); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        bus_if.rx_full_i = 1'b1;
        queue_word(8'h0F, 8'hF0);
        repeat (10) @(posedge clk);
        #1;
        total++; if (pulls !== 0) begin bad++; $display("FAIL bp_no_pull: got %0d want 0", pulls); end
        total++; if (bus_if.busy_o !== 1'b0) begin bad++; $display("FAIL bp_idle: got %b want 0", bus_if.busy_o); end
        bus_if.rx_full_i = 1'b0;
        @(posedge clk); #1;
        total++; if (bus_if.tx_pull_o !== 1'b1) begin bad++; $display("FAIL bp_load: got %b want 1", bus_if.tx_pull_o); end
        wait_rx(1, 100, ok);
        total++; if (rx_got[0] !== 8'hF0) begin bad++; $display("FAIL bp_rx: got %h want f0", rx_got[0]); end
    endtask

    task automatic test_enable_drop();
        bit ok;
        clear_mon();
        queue_word(8'h96, 8'h69);
        queue_word(8'h33, 8'hCC);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rises >= 3 && bus_if.sclk_o == 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++; if (!ok) begin bad++; $display("FAIL en_reach_half5: got %0d rises want 3", rises); end
        bus_if.enable_i = 1'b0;
        wait_rx(1, 100, ok);
        total++; if (rx_got[0] !== 8'h69) begin bad++; $display("FAIL en_rx0: got %h want 69", rx_got[0]); end
        repeat (20) @(posedge clk);
        #1;
        total++; if (pulls !== 1) begin bad++; $display("FAIL en_held: got %0d pulls want 1", pulls); end
        total++; if (bus_if.busy_o !== 1'b0) begin bad++; $display("FAIL en_idle: got %b want 0", bus_if.busy_o); end
        bus_if.enable_i = 1'b1;
        @(posedge clk); #1;
        total++; if (bus_if.tx_pull_o !== 1'b1) begin bad++; $display("FAIL en_resume: got %b want 1", bus_if.tx_pull_o); end
        wait_rx(2, 100, ok);
        total++; if (rx_got[1] !== 8'hCC) begin bad++; $display("FAIL en_rx1: got %h want cc", rx_got[1]); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        queue_word(8'hE1, 8'h1E);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rises >= 4) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        total++; if (!ok) begin bad++; $display("FAIL mid_reach_shift: got %0d rises want 4", rises); end
        rst_n = 1'b0;
        @(posedge clk); #1;
        total++; if (bus_if.busy_o !== 1'b0) begin bad++; $display("FAIL mid_busy: got %b want 0", bus_if.busy_o); end
        total++; if (bus_if.cs_n_o !== 1'b1) begin bad++; $display("FAIL mid_cs_n: got %b want 1", bus_if.cs_n_o); end
        total++; if (bus_if.sclk_o !== 1'b0) begin bad++; $display("FAIL mid_sclk: got %b want 0", bus_if.sclk_o); end
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        total++; if (pushes !== 0) begin bad++; $display("FAIL mid_no_push: got %0d want 0", pushes); end
        total++; if (bus_if.busy_o !== 1'b0) begin bad++; $display("FAIL mid_stay_idle: got %b want 0", bus_if.busy_o); end
    endtask

`ifdef SPI_XFER_CTRL_LOOPBACK_EN
    task automatic test_loopback();
        bit ok;
        clear_mon();
        loopback = 1'b1;
        queue_word(8'h5A, 8'h00);
        wait_rx(1, 100, ok);
        total++; if (rx_got[0] !== 8'h5A) begin bad++; $display("FAIL loopback_rx: got %h want 5a", rx_got[0]); end
        loopback = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_word();
        test_back_to_back();
        test_backpressure();
        test_enable_drop();
        test_reset_mid();
`ifdef SPI_XFER_CTRL_LOOPBACK_EN
        test_loopback();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/spi_xfer_ctrl.md
Name: spi_xfer_ctrl

Overview:
- SPI master transfer sequencer between the AXI-side TX/RX word FIFOs and the SPI pins.
- Pulls one word from the first-word-fall-through TX FIFO and serialises it MSB-first in SPI mode 0, capturing MISO at the same time.
- Pushes the received word into the RX FIFO.
- Starts a word only when the RX FIFO can accept its result.

Parameters:
- g_width, 32: word width in bits (≥2); matches FIFO g_width.
- g_div, 4: SCLK half-period in clk_i cycles (≥1).
- g_gap, 2: extra inter-word cycles with cs_n_o high (≥0).

Ports:
- clk_i  in  1  system clock; single clock domain.
- rst_i  in  1  reset; synchronous, active-low.
- enable_i  in  1  permits new words to start.
- tx_data_i  in  g_width  TX FIFO head word; valid when tx_empty_i=0.
- tx_empty_i  in  1  TX FIFO empty.
- tx_pull_o  out  1  one-cycle pop strobe to TX FIFO.
- rx_data_o  out  g_width  received word to RX FIFO.
- rx_full_i  in  1  RX FIFO full.
- rx_push_o  out  1  one-cycle push strobe to RX FIFO.
- sclk_o  out  1  SPI clock; idles low.
- mosi_o  out  1  SPI data out.
- miso_i  in  1  SPI data in; already synchronised externally.
- cs_n_o  out  1  chip select, active-low.
- busy_o  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_i=0 at a clk_i edge): state IDLE; cs_n_o=1, sclk_o=0, mosi_o=0, tx_pull_o=0, rx_push_o=0, busy_o=0, rx_data_o=0, all counters 0.
- Reset mid-word aborts the word. A word already pulled is discarded and nothing is pushed.
- All outputs are registered.
- States: IDLE, LOAD, SETUP, SHIFT, STORE, GAP.
- IDLE: leave to LOAD when enable_i=1, tx_empty_i=0 and rx_full_i=0 are all true in the same cycle; otherwise stay.
- LOAD (1 cycle):
  - tx_pull_o=1.
  - tx_shift <= tx_data_i; rx_shift <= 0.
  - mosi_o <= tx_data_i[g_width-1].
  - Always go to SETUP.
- SETUP (g_div cycles): cs_n_o=0, sclk_o=0. This is the data setup before the first rising edge.
- SHIFT: 2*g_width half-periods of g_div cycles each.
  - Half-period k has sclk_o=1 for even k and 0 for odd k.
  - In the last cycle of each high half-period: rx_shift <= {rx_shift[g_width-2:0], miso_i}.
  - At each high→low transition, except the final one: tx_shift shifts left by one; mosi_o takes the new MSB.
  - After half-period 2*g_width-1 ends, go to STORE.
- STORE (1 cycle):
  - cs_n_o=1, sclk_o=0.
  - rx_data_o <= rx_shift; rx_push_o=1.
  - No rx_full_i check is needed: fullness was checked at start and this block is the only pusher.
  - Go to GAP if g_gap>0, else IDLE.
- GAP (g_gap cycles): cs_n_o=1, then IDLE.
- enable_i is sampled only in IDLE. Dropping it mid-word lets the current word complete.
- Back-to-back words: per-word period = 1 + g_div + 2*g_width*g_div + 1 + g_gap + 1 (IDLE) cycles.
  - Example: g_width=8, g_div=2, g_gap=1 gives 38 cycles.
  - cs_n_o minimum high time is g_gap+3 cycles.
- tx_pull_o and rx_push_o are never asserted in the same cycle. Each is asserted exactly once per word.
- Counters:
  - div_cnt: width clog2(g_div)+1.
  - half_cnt: width clog2(2*g_width)+1.
  - No wrap occurs inside a word; both clear on every state entry.

Optional Feature:
- Macro: SPI_XFER_CTRL_LOOPBACK_EN.
- Defined: adds input port loopback_i (1 bit). When loopback_i=1, the internal MISO source is mosi_o and miso_i is ignored. When 0, MISO comes from miso_i.
- Undefined: the port is absent and MISO always comes from miso_i. Timing is identical in both builds.

Decomposition:
- Package spi_ctrl_pkg:
  - State encoding constants: IDLE=0, LOAD=1, SETUP=2, SHIFT=3, STORE=4, GAP=5; 3-bit state.
  - clog2 function, shared with fifo.
  - SPI mode constants (CPOL=0, CPHA=0), documented only.
- Sub-module spi_clk_div:
  - Half-period counter with a clear input.
  - Emits a one-cycle tick in the last cycle of each g_div period.
  - The FSM consumes the tick for SETUP/SHIFT timing.

Test Plan:
1. Reset: hold rst_i=0 for 3 clk_i cycles with tx_empty_i=0 → cs_n_o=1, sclk_o=0, no tx_pull_o; first LOAD occurs 1 cycle after rst_i=1.
2. Single word, g_width=8, g_div=2, TX head 0xA5, slave returns 0x3C → mosi_o shows 1,0,1,0,0,1,0,1 at rising edges; exactly 8 SCLK rising edges; rx_push_o once with rx_data_o=0x3C.
3. Back-to-back, 3 words queued, g_gap=1 → tx_pull_o pulses 38 cycles apart; cs_n_o high ≥4 cycles between words; RX order matches TX order.
4. Backpressure: rx_full_i=1 with TX non-empty → stays IDLE, no pull; drop rx_full_i → LOAD on the next cycle.
5. enable_i dropped at half_cnt=5 → word completes with push; no next LOAD until enable_i=1.
6. Reset asserted mid-SHIFT → IDLE next edge, cs_n_o=1, no rx_push_o. With SPI_XFER_CTRL_LOOPBACK_EN and loopback_i=1, TX 0x5A yields RX 0x5A.
